// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for an AHB transfer size and byte offset.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] offset,
  output logic [3:0] byte_en,
  output logic       misalign
);

  // Illegal sizes yield no lanes; the caller flags them as errors separately.
  always_comb begin
    byte_en  = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      SZ_BYTE: byte_en = 4'b0001 << offset;
      SZ_HALF: begin
        byte_en  = 4'b0011 << offset;
        misalign = offset[0];
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        misalign = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: word array with byte lanes, programmable wait states,
// two-cycle ERROR response and a write-protected low code region.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RO_WORDS    = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [1:0]  dbg_state
);

  localparam int         IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0]   mem [DEPTH_WORDS];
  slv_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic [3:0]    be_q;
  logic          write_q;

  logic [3:0] be_a;
  logic       misalign_a, err_a, accept, ready_phase, take, commit;
  logic       unused_ok;

  assign unused_ok = ^{hprot, htrans[0]};

  ahb_byte_strobe u_strobe (
    .hsize   (hsize),
    .offset  (haddr[1:0]),
    .byte_en (be_a),
    .misalign(misalign_a)
  );

  // Handshake: an address phase is taken on a rising edge with hsel, hready_in
  // and a NONSEQ/SEQ htrans, but only while this slave is not stalling its own
  // data phase; the data phase completes on the edge where hreadyout is 1.
  assign accept = hsel & hready_in & htrans[1];
  assign err_a  = (hsize > SZ_WORD) | misalign_a
                | (haddr[31:2] >= 30'(DEPTH_WORDS))
                | (hwrite & (haddr[31:2] < 30'(RO_WORDS)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    ready_phase = 1'b0;
    case (state_q)
      ST_IDLE: ready_phase = 1'b1;
      ST_DATA: begin
        hreadyout = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_phase = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp       = HRESP_ERROR;
        ready_phase = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    take = ready_phase & accept;
    if (take) begin
      state_d = err_a ? ST_ERR1 : ST_DATA;
      cnt_d   = WS;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= haddr[IW+1:2];
        be_q    <= be_a;
        write_q <= hwrite;
      end
    end
  end

  // Errored transfers never reach DATA, so only legal writes commit here.
  assign commit = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata    = (state_q == ST_DATA) ? mem[idx_q] : 32'h0;
  assign dbg_state = state_q;

endmodule
